framebuffer_axi_mover: RTL and testbench

FRAMEBUFFER_AXI_MOVER -- requirements
Module: framebuffer_axi_mover

---
 rtl/framebuffer_axi_mover.sv | 239 +++++++++++++++++++++++
 tb/tb_framebuffer_axi_mover.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_axi_mover.sv
// framebuffer_axi_mover
//   Moves a contiguous block of beats between an AXI4 memory and a pair of
//   AXI-Stream ports. A command (start address, beat count, direction) is
//   split into INCR bursts that never exceed 2^MAX_BURST_LG beats and never
//   cross a 4 KiB boundary. At most one burst is in flight. Data is not
//   buffered: W is fed straight from s_axis, and m_axis straight from R.
//
// Ports
//   aclk, reset                 clock, synchronous active-high reset
//   s_avalid/s_aready           command handshake
//   s_aaddr, s_abeats, s_arnw   start byte address, beat count, 1 = write
//   s_axis_*                    stream in, written to memory
//   m_axis_*                    stream out, read from memory
//   aw*/w*/b*/ar*/r*            AXI4 master channels
//   busy                        high whenever a command is in progress
//   errResp                     sticky: a non-OKAY bresp/rresp was seen
//   errLast                     sticky: s_axis_tlast disagreed with the final beat
module framebuffer_axi_mover #(
    parameter int STREAM_WIDTH = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_BURST_LG = 4
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      s_avalid,
    output logic                      s_aready,
    input  logic [ADDR_WIDTH-1:0]     s_aaddr,
    input  logic [ADDR_WIDTH-1:0]     s_abeats,
    input  logic                      s_arnw,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]   s_axis_tdata,
    input  logic [STREAM_WIDTH/8-1:0] s_axis_tstrb,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]   m_axis_tdata,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [STREAM_WIDTH-1:0]   wdata,
    output logic [STREAM_WIDTH/8-1:0] wstrb,
    output logic                      wlast,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [STREAM_WIDTH-1:0]   rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    output logic                      busy,
    output logic                      errResp,
    output logic                      errLast
);

    localparam int          BYTES     = STREAM_WIDTH / 8;
    localparam int          SIZE_LG   = $clog2(BYTES);
    localparam logic [12:0] MAX_BURST = 13'(2 ** MAX_BURST_LG);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] remaining_q;
    logic [8:0]            beat_cnt_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  err_resp_q;
    logic                  err_last_q;
    logic [8:0]            burst_l;
    logic                  last_in_burst;
    logic                  final_beat;
    logic                  unused_rlast;

    // Beats in the next burst: limited by what is left, the burst cap and
    // the distance to the next 4 KiB page (addresses are beat-aligned, so
    // the page distance is always a whole, non-zero number of beats).
    function automatic logic [8:0] burst_len(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [ADDR_WIDTH-1:0] remaining);
        logic [12:0] to_page;
        logic [12:0] cap;
        to_page = (13'h1000 - {1'b0, addr[11:0]}) >> SIZE_LG;
        cap     = (to_page < MAX_BURST) ? to_page : MAX_BURST;
        if (remaining < ADDR_WIDTH'(cap))
            burst_len = 9'(remaining);
        else
            burst_len = 9'(cap);
    endfunction

    // addr_q/remaining_q only change on the address handshake, so the
    // burst fields stay stable for as long as a*valid is held.
    assign burst_l       = burst_len(addr_q, remaining_q);
    assign last_in_burst = (beat_cnt_q == 9'd1);
    assign final_beat    = last_in_burst && (remaining_q == '0);

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awlen   = 8'(burst_l - 9'd1);
    assign awsize  = 3'(SIZE_LG);
    assign awburst = 2'b01;
    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arlen   = 8'(burst_l - 9'd1);
    assign arsize  = 3'(SIZE_LG);
    assign arburst = 2'b01;

    assign wdata        = s_axis_tdata;
    assign wstrb        = s_axis_tstrb;
    assign m_axis_tdata = rdata;

    assign busy    = (state_q != IDLE);
    assign errResp = err_resp_q;
    assign errLast = err_last_q;

    // Burst ends are tracked by the beat counter, so rlast is not needed.
    assign unused_rlast = rlast;

    always_comb begin
        state_d       = state_q;
        s_aready      = 1'b0;
        s_axis_tready = 1'b0;
        wvalid        = 1'b0;
        wlast         = 1'b0;
        bready        = 1'b0;
        rready        = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                s_aready = 1'b1;
                if (s_avalid && (s_abeats != '0))
                    state_d = s_arnw ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                if (awvalid_q && awready)
                    state_d = WR_DATA;
            end
            WR_DATA: begin
                wvalid        = s_axis_tvalid;
                s_axis_tready = wready;
                wlast         = last_in_burst;
                if (s_axis_tvalid && wready && last_in_burst)
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid)
                    state_d = (remaining_q == '0) ? IDLE : WR_ADDR;
            end
            RD_ADDR: begin
                if (arvalid_q && arready)
                    state_d = RD_DATA;
            end
            RD_DATA: begin
                m_axis_tvalid = rvalid;
                rready        = m_axis_tready;
                m_axis_tlast  = final_beat;
                if (rvalid && m_axis_tready && last_in_burst)
                    state_d = (remaining_q == '0) ? IDLE : RD_ADDR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            err_resp_q  <= 1'b0;
            err_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            // a*valid is raised on entry to the address state and held there
            awvalid_q <= (state_d == WR_ADDR);
            arvalid_q <= (state_d == RD_ADDR);
            case (state_q)
                IDLE: begin
                    if (s_avalid) begin
                        addr_q      <= s_aaddr;
                        remaining_q <= s_abeats;
                        err_resp_q  <= 1'b0;
                        err_last_q  <= 1'b0;
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    if ((awvalid_q && awready) || (arvalid_q && arready)) begin
                        addr_q      <= addr_q + (ADDR_WIDTH'(burst_l) << SIZE_LG);
                        remaining_q <= remaining_q - ADDR_WIDTH'(burst_l);
                        beat_cnt_q  <= burst_l;
                    end
                end
                WR_DATA: begin
                    if (s_axis_tvalid && wready) begin
                        beat_cnt_q <= beat_cnt_q - 9'd1;
                        if (s_axis_tlast != final_beat)
                            err_last_q <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bvalid && (bresp != 2'b00))
                        err_resp_q <= 1'b1;
                end
                RD_DATA: begin
                    if (rvalid && m_axis_tready) begin
                        beat_cnt_q <= beat_cnt_q - 9'd1;
                        if (rresp != 2'b00)
                            err_resp_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_axi_mover.sv
// Directed bench for framebuffer_axi_mover with a small AXI4 slave memory
// and stream source/sink. Inputs change on the falling edge; handshakes are
// sampled 3 time units later, i.e. just before the rising edge that uses them.
module tb_framebuffer_axi_mover;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        s_avalid = 1'b0;
    logic        s_aready;
    logic [31:0] s_aaddr = '0;
    logic [31:0] s_abeats = '0;
    logic        s_arnw = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tstrb = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = 2'b00;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;
    logic        busy;
    logic        errResp;
    logic        errLast;

    framebuffer_axi_mover dut (
        .aclk(aclk), .reset(reset),
        .s_avalid(s_avalid), .s_aready(s_aready), .s_aaddr(s_aaddr),
        .s_abeats(s_abeats), .s_arnw(s_arnw),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .s_axis_tstrb(s_axis_tstrb),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .busy(busy), .errResp(errResp), .errLast(errLast)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // bench configuration
    int       src_len = 0;
    int       tlast_at = -1;
    bit       gap_en = 1'b0;
    bit       tready_toggle = 1'b0;
    logic [1:0] bresp_cfg = 2'b00;
    int       w_stop = 1 << 30;

    // slave / stream state
    logic [63:0] mem [0:2047];
    int          src_idx = 0;
    int          w_count = 0;
    int          wd_bad = 0;
    int          b_count = 0;
    bit          b_pending = 1'b0;
    logic [31:0] w_addr = '0;
    logic [31:0] r_addr = '0;
    int          r_remaining = 0;
    int          rr_checks = 0;
    int          rr_bad = 0;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [2:0]  ax_size_seen = '0;
    logic [1:0]  ax_burst_seen = '0;
    int          wlast_q[$];
    logic [63:0] rx_q[$];
    logic        rx_last_q[$];

    function automatic logic [63:0] wpat(input int k);
        return {16'hBEEF, 16'(k), 32'h600D_0000 + 32'(k)};
    endfunction

    function automatic logic [7:0] spat(input int k);
        return {4'hF, 4'(k * 5)};
    endfunction

    function automatic logic [63:0] rpat(input int i);
        return {32'hA500_0000 | 32'(i), ~32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // AXI slave memory, stream source and stream sink
    initial begin : bfm
        forever begin
            @(negedge aclk);
            awready = gap_en ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = (w_count >= w_stop) ? 1'b0 : (gap_en ? 1'($urandom_range(0, 1)) : 1'b1);
            bvalid  = b_pending;
            bresp   = bresp_cfg;
            arready = 1'b1;
            rvalid  = (r_remaining > 0);
            rdata   = mem[r_addr[13:3]];
            rlast   = (r_remaining == 1);
            rresp   = 2'b00;
            s_axis_tvalid = (src_idx < src_len) && (gap_en ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_axis_tdata  = wpat(src_idx);
            s_axis_tstrb  = spat(src_idx);
            s_axis_tlast  = (src_idx == tlast_at);
            m_axis_tready = tready_toggle ? ~m_axis_tready : 1'b1;
            #3;
            if (reset) begin
                b_pending   = 1'b0;
                r_remaining = 0;
            end else begin
                if (r_remaining > 0) begin
                    rr_checks++;
                    if (rready !== m_axis_tready || m_axis_tvalid !== rvalid) rr_bad++;
                end
                if (awvalid && awready) begin
                    aw_addr_q.push_back(awaddr);
                    aw_len_q.push_back(awlen);
                    ax_size_seen  = awsize;
                    ax_burst_seen = awburst;
                    w_addr = awaddr;
                end
                if (wvalid && wready) begin
                    if (wdata !== wpat(w_count) || wstrb !== spat(w_count)) wd_bad++;
                    mem[w_addr[13:3]] = wdata;
                    w_addr += 32'd8;
                    if (wlast) begin
                        wlast_q.push_back(w_count + 1);
                        b_pending = 1'b1;
                    end
                    w_count++;
                end
                if (s_axis_tvalid && s_axis_tready) src_idx++;
                if (bvalid && bready) begin
                    b_pending = 1'b0;
                    b_count++;
                end
                if (arvalid && arready) begin
                    ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(arlen);
                    ax_size_seen  = arsize;
                    ax_burst_seen = arburst;
                    r_addr = araddr;
                    r_remaining = int'(arlen) + 1;
                end
                if (rvalid && rready) begin
                    r_remaining--;
                    r_addr += 32'd8;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    rx_q.push_back(m_axis_tdata);
                    rx_last_q.push_back(m_axis_tlast);
                end
            end
        end
    end

    task automatic tick();
        @(negedge aclk);
        #4;
    endtask

    task automatic prep(input int beats, input int last_at, input bit gaps,
                        input bit tog, input logic [1:0] br);
        aw_addr_q.delete(); aw_len_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
        wlast_q.delete(); rx_q.delete(); rx_last_q.delete();
        src_idx = 0; w_count = 0; wd_bad = 0; b_count = 0;
        rr_checks = 0; rr_bad = 0;
        src_len = beats; tlast_at = last_at; gap_en = gaps;
        tready_toggle = tog; bresp_cfg = br; w_stop = 1 << 30;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] beats, input logic rnw);
        @(negedge aclk);
        s_aaddr = addr; s_abeats = beats; s_arnw = rnw; s_avalid = 1'b1;
        @(negedge aclk);
        s_avalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (!busy) break;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic init_mem();
        for (int i = 0; i < 2048; i++) mem[i] = rpat(i);
    endtask

    initial begin : main
        int rx_bad;
        int zb_bad;
        int last_cnt;
        init_mem();

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs",
              64'({s_aready, busy, awvalid, arvalid, wvalid, bready, rready,
                   s_axis_tready, m_axis_tvalid, errResp, errLast}),
              64'b1_0000_0000_00);
        @(negedge aclk);
        reset = 1'b0;

        // write 0x1000, 20 beats: bursts of 16 then 4
        prep(20, 19, 1'b0, 1'b0, 2'b00);
        issue(32'h1000, 32'd20, 1'b1);
        wait_idle("wr20_done", 200);
        check("wr20_aw_count", 64'(aw_addr_q.size()), 64'd2);
        check("wr20_aw0_addr", 64'(aw_addr_q[0]), 64'h1000);
        check("wr20_aw0_len",  64'(aw_len_q[0]), 64'd15);
        check("wr20_aw1_addr", 64'(aw_addr_q[1]), 64'h1080);
        check("wr20_aw1_len",  64'(aw_len_q[1]), 64'd3);
        check("wr20_awsize",   64'(ax_size_seen), 64'd3);
        check("wr20_awburst",  64'(ax_burst_seen), 64'd1);
        check("wr20_wlast_n",  64'(wlast_q.size()), 64'd2);
        check("wr20_wlast0",   64'(wlast_q[0]), 64'd16);
        check("wr20_wlast1",   64'(wlast_q[1]), 64'd20);
        check("wr20_beats",    64'(w_count), 64'd20);
        check("wr20_data",     64'(wd_bad), 64'd0);
        check("wr20_b_count",  64'(b_count), 64'd2);
        check("wr20_mem_last", mem[(32'h1000 >> 3) + 19], wpat(19));
        check("wr20_errs",     64'({errResp, errLast}), 64'd0);

        // read 0x0FF0, 8 beats: split at the 4 KiB page
        init_mem();
        prep(0, -1, 1'b0, 1'b0, 2'b00);
        issue(32'h0FF0, 32'd8, 1'b0);
        wait_idle("rd8_done", 200);
        check("rd8_ar_count", 64'(ar_addr_q.size()), 64'd2);
        check("rd8_ar0_addr", 64'(ar_addr_q[0]), 64'h0FF0);
        check("rd8_ar0_len",  64'(ar_len_q[0]), 64'd1);
        check("rd8_ar1_addr", 64'(ar_addr_q[1]), 64'h1000);
        check("rd8_ar1_len",  64'(ar_len_q[1]), 64'd5);
        check("rd8_arsize",   64'(ax_size_seen), 64'd3);
        check("rd8_beats",    64'(rx_q.size()), 64'd8);
        rx_bad = 0; last_cnt = 0;
        foreach (rx_q[k]) begin
            if (rx_q[k] !== rpat((32'h0FF0 >> 3) + k)) rx_bad++;
            if (rx_last_q[k]) last_cnt++;
        end
        check("rd8_data",     64'(rx_bad), 64'd0);
        check("rd8_tlast_n",  64'(last_cnt), 64'd1);
        check("rd8_tlast_b8", 64'(rx_last_q[7]), 64'd1);
        check("rd8_aw_none",  64'(aw_addr_q.size()), 64'd0);

        // write 4 beats with random gaps and SLVERR response
        prep(4, 3, 1'b1, 1'b0, 2'b10);
        issue(32'h2000, 32'd4, 1'b1);
        wait_idle("wr4err_done", 400);
        check("wr4err_aw_len", 64'(aw_len_q[0]), 64'd3);
        check("wr4err_beats",  64'(w_count), 64'd4);
        check("wr4err_data",   64'(wd_bad), 64'd0);
        check("wr4err_errResp", 64'(errResp), 64'd1);

        // zero-length command: no bus activity, still clears errResp
        prep(0, -1, 1'b0, 1'b0, 2'b00);
        issue(32'h4000, 32'd0, 1'b1);
        zb_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!s_aready || busy || awvalid || arvalid) zb_bad++;
        end
        check("zero_idle",    64'(zb_bad), 64'd0);
        check("zero_no_ax",   64'(aw_addr_q.size() + ar_addr_q.size()), 64'd0);
        check("zero_clr_err", 64'(errResp), 64'd0);

        // read 16 beats with m_axis_tready toggling every cycle
        init_mem();
        prep(0, -1, 1'b0, 1'b1, 2'b00);
        issue(32'h0100, 32'd16, 1'b0);
        wait_idle("rd16_done", 300);
        tready_toggle = 1'b0;
        check("rd16_ar_len", 64'(ar_len_q[0]), 64'd15);
        check("rd16_mirror", 64'(rr_bad), 64'd0);
        check("rd16_mirror_seen", 64'(rr_checks >= 16), 64'd1);
        check("rd16_beats",  64'(rx_q.size()), 64'd16);
        rx_bad = 0; last_cnt = 0;
        foreach (rx_q[k]) begin
            if (rx_q[k] !== rpat((32'h0100 >> 3) + k)) rx_bad++;
            if (rx_last_q[k]) last_cnt++;
        end
        check("rd16_data",    64'(rx_bad), 64'd0);
        check("rd16_tlast_n", 64'(last_cnt), 64'd1);

        // write 3 beats with tlast on beat 2
        prep(3, 1, 1'b0, 1'b0, 2'b00);
        issue(32'h2800, 32'd3, 1'b1);
        wait_idle("wr3_done", 200);
        check("wr3_errLast", 64'(errLast), 64'd1);
        check("wr3_beats",   64'(w_count), 64'd3);
        check("wr3_data",    64'(wd_bad), 64'd0);
        check("wr3_errResp", 64'(errResp), 64'd0);

        // reset while in WR_DATA after beat 2
        prep(8, 7, 1'b0, 1'b0, 2'b00);
        w_stop = 2;
        issue(32'h3000, 32'd8, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (w_count >= 2) break;
        end
        check("rst_mid_beats", 64'(w_count), 64'd2);
        @(negedge aclk);
        reset = 1'b1;
        @(posedge aclk);
        #1;
        check("rst_mid_outputs",
              64'({s_aready, busy, awvalid, arvalid, wvalid, bready, rready,
                   s_axis_tready, m_axis_tvalid}),
              64'b1_0000_0000);
        @(negedge aclk);
        src_len = 0;
        reset = 1'b0;
        tick();
        check("rst_mid_idle", 64'({s_aready, busy}), 64'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
